// File: rtl/i2c_cmd_arbiter.sv
// Purpose: round-robin arbiter that shares one I2C master between NUM_REQ register-access requesters.
// Latency: grant one cycle after req is sampled, master enable on the next cycle, done one cycle after m_done.
// Backpressure: one command outstanding; others hold req until their done. Optional macro I2C_ARB_TIMEOUT_EN aborts a stuck WAIT.
module i2c_cmd_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_slave_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]     req_rw,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   ack_err,
    output logic [7:0]             rdata,
    output logic                   m_enable,
    output logic [6:0]             m_slave_addr,
    output logic [7:0]             m_reg_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_read_write,
    input  logic                   m_done,
    input  logic                   m_ack_err,
    input  logic [7:0]             m_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    // Reject configurations the pointer arithmetic and 16-bit wait counter cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
        $error("i2c_cmd_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPLETE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, win_q, pick;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                ack_err_q;
    logic [7:0]          rdata_q;
    logic [6:0]          slave_addr_q;
    logic [7:0]          reg_addr_q;
    logic [7:0]          data_in_q;
    logic                read_write_q;
    logic                any_req;
    logic                wait_tmo;
    logic [IW-1:0]       cand;
    int                  sum;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    // Wait counter: zeroed while issuing so it reads 0 on the first WAIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  wait_cnt_q <= '0;
        else if (state_q == S_ISSUE) wait_cnt_q <= '0;
        else if (state_q == S_WAIT)  wait_cnt_q <= wait_cnt_q + 16'd1;
    end

    assign wait_tmo = (state_q == S_WAIT) && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign wait_tmo = 1'b0;
`endif

    // Round-robin pick: scan downward so the set bit closest to rr_ptr is written last and wins
    always_comb begin
        pick    = rr_ptr_q;
        any_req = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = IW'(sum);
            if (req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; m_done only matters while waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (any_req) state_d = S_ISSUE;
            S_ISSUE:    state_d = S_WAIT;
            S_WAIT:     if (m_done || wait_tmo) state_d = S_COMPLETE;
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath: latch winner's command, capture result, advance the round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q     <= '0;
            win_q        <= '0;
            gnt_q        <= '0;
            ack_err_q    <= 1'b0;
            rdata_q      <= '0;
            slave_addr_q <= '0;
            reg_addr_q   <= '0;
            data_in_q    <= '0;
            read_write_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        win_q        <= pick;
                        gnt_q        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        slave_addr_q <= req_slave_addr[7*int'(pick) +: 7];
                        reg_addr_q   <= req_reg_addr[8*int'(pick) +: 8];
                        data_in_q    <= req_wdata[8*int'(pick) +: 8];
                        read_write_q <= req_rw[pick];
                    end
                end
                S_WAIT: begin
                    // A real completion beats a coincident timeout
                    if (m_done) begin
                        ack_err_q <= m_ack_err;
                        if (read_write_q && !m_ack_err) rdata_q <= m_rdata;
                    end else if (wait_tmo) begin
                        ack_err_q <= 1'b1;
                    end
                end
                S_COMPLETE: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output decode: single-cycle enable and done pulses follow the state directly
    always_comb begin
        m_enable = 1'b0;
        done     = '0;
        if (state_q == S_ISSUE)    m_enable = 1'b1;
        if (state_q == S_COMPLETE) done     = gnt_q;
    end

    assign gnt          = gnt_q;
    assign ack_err      = ack_err_q;
    assign rdata        = rdata_q;
    assign m_slave_addr = slave_addr_q;
    assign m_reg_addr   = reg_addr_q;
    assign m_data_in    = data_in_q;
    assign m_read_write = read_write_q;

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one I2C master between NUM_REQ requesters.
- Accepts complete register-access commands (slave address, register address, write data, direction) and grants them round-robin.
- Issues each command to the master as a one-cycle enable pulse, waits for completion, then returns read data and ACK status to the winning requester.
- Sits between the system-side register-access clients and the I2C master.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester command request; level, held until matching done.
- req_slave_addr  input  7*NUM_REQ  7-bit slave address; requester i at bits [7i+6:7i].
- req_reg_addr  input  8*NUM_REQ  register address per requester.
- req_wdata  input  8*NUM_REQ  write byte per requester.
- req_rw  input  NUM_REQ  1 = read, 0 = write.
- gnt  output  NUM_REQ  one-hot grant; high from latch until done.
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- ack_err  output  1  1 = slave NACK (or timeout) on the last completed command.
- rdata  output  8  read byte from the last completed read.
- m_enable  output  1  one-cycle start pulse to the I2C master.
- m_slave_addr  output  7  latched command field to the master.
- m_reg_addr  output  8  latched command field to the master.
- m_data_in  output  8  latched command field to the master.
- m_read_write  output  1  latched command field to the master.
- m_done  input  1  master completion pulse.
- m_ack_err  input  1  master NACK flag, valid with m_done.
- m_rdata  input  8  master read byte, valid with m_done.

Behaviour:
Reset (reset=0):
- Asynchronous and immediate: state=IDLE; rr_ptr=0.
- All outputs 0: gnt, done, m_enable, ack_err, rdata, and all m_* fields.
- Reset mid-transaction aborts the command. No done is issued.

State machine: IDLE, ISSUE, WAIT, COMPLETE.

IDLE:
- If any req bit is set, winner = first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- On that edge: latch the winner's fields into m_slave_addr, m_reg_addr, m_data_in, m_read_write; set gnt[winner]=1; go to ISSUE.
- Grant latency: one cycle from req sampled.

ISSUE:
- m_enable=1 for exactly this one cycle; go to WAIT.

WAIT:
- m_enable=0.
- On m_done=1: ack_err<=m_ack_err. If m_read_write=1 and m_ack_err=0, then rdata<=m_rdata; otherwise rdata holds. Go to COMPLETE.
- m_done is sampled only in WAIT and ignored in all other states.

COMPLETE:
- done[winner]=1 for one cycle; gnt cleared at end of the cycle.
- rr_ptr<=(winner+1) mod NUM_REQ; go to IDLE.

Command fields:
- m_* fields are stable from ISSUE until the next grant.
- Requester input changes after grant have no effect.

Arbitration and request rules:
- The requester drops req on done. req still high in IDLE is a new command, arbitrated behind the other requesters.
- req deasserted mid-transaction: the command still completes and done still pulses.
- Only one command outstanding; gnt is always one-hot or zero.

Result outputs:
- ack_err and rdata hold until the next completion.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES-1 with no m_done: ack_err<=1, rdata unchanged, go to COMPLETE (done pulses normally).
  - m_done coincident with the terminal count wins, giving a normal completion.
- Not defined: no counter; WAIT holds indefinitely until m_done.

Test Plan:
- Single write: req=01, slave 0x50, reg 0x10, wdata 0xA5, rw=0 -> gnt=01 next cycle; m_enable pulses once with fields 0x50/0x10/0xA5/0; m_done with m_ack_err=0 -> done=01 one cycle, ack_err=0, rdata unchanged at 0x00.
- Read: req[1]=1, rw=1; m_done with m_rdata=0x3C, m_ack_err=0 -> done=10, rdata=0x3C, ack_err=0.
- Contention: req=11 held continuously from reset -> grants alternate 01,10,01,10; each gnt one-hot, never both.
- NACK: read with m_done and m_ack_err=1, m_rdata=0xFF -> ack_err=1, rdata keeps previous 0x3C.
- Reset mid-WAIT: reset=0 -> gnt, m_enable and done go 0 immediately. After release, req=01 -> new grant to requester 0 (rr_ptr=0).
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no m_done -> done pulses 16 cycles after WAIT entry with ack_err=1. Without the macro -> no done after 100 cycles.
